// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot engine fabric.
// Used by the result arbiter and the work distributor.
package mandelbrot_pkg;

    localparam int N_ENGINES = 12;
    localparam int PIX_W     = 32;
    localparam int CH_W      = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sop;
        logic             eop;
    } beat_t;

endpackage

// File: rtl/mandelbrot_rr_pick.sv
// Round-robin priority search: first set bit of req at or above ptr, wrapping to 0.
// Purely combinational; shared by the result arbiter and the work distributor.
module mandelbrot_rr_pick #(
    parameter int N    = 12,
    parameter int CH_W = 4
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant,
    output logic            found
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant = '0;
        found = 1'b0;
        // Upper segment [ptr, N-1] first, then wrap to [0, ptr-1].
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant = CH_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mandelbrot_result_arbiter.sv
// Packet-granular round-robin merge of N pixel-engine result streams into one tagged stream,
// with a completed-packet counter, busy flag and sticky protocol-error flag.
module mandelbrot_result_arbiter #(
    parameter int N_PORTS = mandelbrot_pkg::N_ENGINES,
    parameter int DATA_W  = mandelbrot_pkg::PIX_W,
    parameter int CH_W    = mandelbrot_pkg::CH_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PORTS-1:0]        port_enable,
    input  logic [N_PORTS*DATA_W-1:0] in_data,
    input  logic [N_PORTS-1:0]        in_valid,
    input  logic [N_PORTS-1:0]        in_sop,
    input  logic [N_PORTS-1:0]        in_eop,
    output logic [N_PORTS-1:0]        in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [CH_W-1:0]           out_channel,
    input  logic                      out_ready,
    output logic [31:0]               pkt_count,
    input  logic                      pkt_count_clr,
    output logic                      busy,
    output logic                      proto_err,
    input  logic                      proto_err_clr
);
    import mandelbrot_pkg::*;

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [31:0]       pkt_count_q, pkt_count_d;
    logic              proto_err_q, proto_err_d;
    logic              first_q, first_d;

    logic [N_PORTS-1:0] req;
    logic [CH_W-1:0]    pick;
    logic               pick_found;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid, sel_sop, sel_eop;
    logic               accept, done, idle_err, dup_sop_err;

    assign req = in_valid & in_sop & port_enable;

    mandelbrot_rr_pick #(.N(N_PORTS), .CH_W(CH_W)) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (pick),
        .found (pick_found)
    );

    // Sink mux follows grant even in IDLE so out_data/out_channel never float.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == CH_W'(i)) begin
                sel_data    = in_data[i*DATA_W +: DATA_W];
                sel_valid   = in_valid[i];
                sel_sop     = in_sop[i];
                sel_eop     = in_eop[i];
                in_ready[i] = busy & out_ready;
            end
        end
    end

    assign busy        = (state_q == ARB_BUSY);
    assign out_data    = sel_data;
    assign out_valid   = busy & sel_valid;
    assign out_sop     = busy & sel_sop;
    assign out_eop     = busy & sel_eop;
    assign out_channel = grant_q;
    assign pkt_count   = pkt_count_q;
    assign proto_err   = proto_err_q;

    assign accept      = out_valid & out_ready;
    assign done        = accept & sel_eop;
    assign idle_err    = (state_q == ARB_IDLE) && (|(port_enable & in_valid & ~in_sop));
    assign dup_sop_err = accept & ~first_q & sel_sop;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        first_d     = first_q;
        pkt_count_d = pkt_count_clr ? '0 : pkt_count_q;
        // A new error in the same cycle as the clear wins.
        proto_err_d = (proto_err_q & ~proto_err_clr) | idle_err | dup_sop_err;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    first_d = 1'b1;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (accept) begin
                    first_d = 1'b0;
                end
                if (done) begin
                    pkt_count_d = pkt_count_d + 32'd1;
                    rr_ptr_d    = (grant_q == CH_W'(N_PORTS - 1)) ? '0 : grant_q + CH_W'(1);
                    state_d     = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            pkt_count_q <= '0;
            proto_err_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            pkt_count_q <= pkt_count_d;
            proto_err_q <= proto_err_d;
            first_q     <= first_d;
        end
    end

endmodule

// File: tb/tb_mandelbrot_result_arbiter.sv
// Bench for mandelbrot_result_arbiter: arbitration vector table, directed corner sequences and
// randomized packet traffic checked against a queue-based packet-level reference model.
module tb_mandelbrot_result_arbiter;
    import mandelbrot_pkg::*;

    localparam int N  = N_ENGINES;
    localparam int DW = PIX_W;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    port_enable;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid, in_sop, in_eop, in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid, out_sop, out_eop, out_ready;
    logic [CH_W-1:0] out_channel;
    logic [31:0]     pkt_count;
    logic            pkt_count_clr, busy, proto_err, proto_err_clr;

    always #5 clk = ~clk;

    mandelbrot_result_arbiter #(.N_PORTS(N), .DATA_W(DW), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .port_enable(port_enable), .in_data(in_data),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_channel(out_channel), .out_ready(out_ready), .pkt_count(pkt_count),
        .pkt_count_clr(pkt_count_clr), .busy(busy), .proto_err(proto_err),
        .proto_err_clr(proto_err_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-port packet queues plus who is being served and the RR pointer.
    beat_t src_q [N][$];
    int    order_q[$];
    int    sop_cyc_q[$];
    bit    ready_pat[$];
    int    m_ptr, m_cur, m_count, cyc;
    bit    m_busy, m_first, m_err;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] en;
        bit           found;
        int           ch;
        int           count;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
        pkt_count_clr = 1'b0; proto_err_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        out_ready = 1'b0;
        port_enable = '1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_ptr = 0; m_count = 0; m_busy = 0; m_err = 0; m_first = 0;
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic load_pkt(input int port, input int len, input bit bad_sop);
        for (int b = 0; b < len; b++) begin
            beat_t bt;
            bt.data = $urandom;
            bt.sop  = (b == 0) || (bad_sop && b == 1);
            bt.eop  = (b == len - 1);
            src_q[port].push_back(bt);
        end
    endtask

    // Called at the negedge with this cycle's inputs stable; applies the arbitration rules.
    task automatic model_step();
        logic [N-1:0] req;
        bit           hit;
        if (!m_busy) begin
            check("idle_out_valid", out_valid, 0);
            check("idle_in_ready", in_ready, 0);
            req = in_valid & in_sop & port_enable;
            for (int i = 0; i < N; i++)
                if (port_enable[i] && in_valid[i] && !in_sop[i]) m_err = 1;
            hit = 0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (!hit && req[p]) begin
                    hit = 1; m_cur = p;
                end
            end
            if (hit) begin
                m_busy = 1; m_first = 1;
                order_q.push_back(m_cur);
            end
        end else begin
            check("busy_flag", busy, 1);
            check("out_valid", out_valid, in_valid[m_cur]);
            check("in_ready", in_ready, out_ready ? (64'd1 << m_cur) : 64'd0);
            check("out_channel", out_channel, m_cur);
            if (in_valid[m_cur]) begin
                check("out_data", out_data, src_q[m_cur][0].data);
                check("out_sop", out_sop, src_q[m_cur][0].sop);
                check("out_eop", out_eop, src_q[m_cur][0].eop);
                if (out_ready) begin
                    if (m_first) sop_cyc_q.push_back(cyc);
                    else if (src_q[m_cur][0].sop) m_err = 1;
                    m_first = 0;
                    if (src_q[m_cur][0].eop) begin
                        m_count++;
                        m_ptr  = (m_cur + 1) % N;
                        m_busy = 0;
                    end
                    void'(src_q[m_cur].pop_front());
                end
            end
        end
    endtask

    // Drives all queued packets through the DUT; entered and left just after a rising edge.
    task automatic run_traffic(input int valid_pct, input int ready_pct, input int en_clr_cyc);
        bit done;
        int n;
        done = 0; n = 0;
        order_q.delete(); sop_cyc_q.delete();
        while (!done) begin
            if (n == en_clr_cyc) port_enable = '0;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                    in_valid[i] = 1'b1;
                    in_sop[i]   = src_q[i][0].sop;
                    in_eop[i]   = src_q[i][0].eop;
                    in_data[i*DW +: DW] = src_q[i][0].data;
                end else begin
                    in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
                end
            end
            if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
            else out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            model_step();
            done = !m_busy;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) done = 0;
            @(posedge clk);
            #1;
            cyc++; n++;
            if (n > 3000) begin
                check("traffic_timeout", n, 0);
                done = 1;
            end
        end
        clear_inputs();
        check("run_pkt_count", pkt_count, m_count);
        check("run_proto_err", proto_err, m_err);
        check("run_busy_after", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        cyc = 0;
        vecs[0] = '{12'h008, 12'hFFF, 1, 3,  1};
        vecs[1] = '{12'h821, 12'hFFF, 1, 5,  2};
        vecs[2] = '{12'h821, 12'hFFF, 1, 11, 3};
        vecs[3] = '{12'h821, 12'hFFF, 1, 0,  4};
        vecs[4] = '{12'h010, 12'h001, 0, 0,  4};
        vecs[5] = '{12'h011, 12'h001, 1, 0,  5};
        vecs[6] = '{12'h003, 12'hFFF, 1, 1,  6};
        vecs[7] = '{12'h003, 12'hFFF, 1, 0,  7};
        vecs[8] = '{12'h800, 12'h800, 1, 11, 8};
        vecs[9] = '{12'hFFF, 12'hFFF, 1, 0,  9};

        do_reset();
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_proto_err", proto_err, 0);

        // Single-beat packets, one per vector, RR pointer carried across vectors.
        for (int v = 0; v < 10; v++) begin
            port_enable = vecs[v].en;
            in_valid = vecs[v].req; in_sop = vecs[v].req; in_eop = vecs[v].req;
            out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_arb_ready", v), in_ready, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("vec%0d_busy", v), busy, vecs[v].found);
            check($sformatf("vec%0d_valid", v), out_valid, vecs[v].found);
            if (vecs[v].found) check($sformatf("vec%0d_channel", v), out_channel, vecs[v].ch);
            @(posedge clk); #1;
            clear_inputs();
            check($sformatf("vec%0d_count", v), pkt_count, vecs[v].count);
        end

        // 4-beat packet on port 3.
        do_reset();
        load_pkt(3, 4, 0);
        run_traffic(100, 100, -1);
        check("p1_order_len", order_q.size(), 1);
        check("p1_channel", order_q[0], 3);
        check("p1_count", pkt_count, 1);

        // Port 5 moves the pointer to 6, then 0/5/11 contend with 2-beat packets.
        load_pkt(5, 1, 0);
        run_traffic(100, 100, -1);
        load_pkt(0, 2, 0); load_pkt(5, 2, 0); load_pkt(11, 2, 0);
        run_traffic(100, 100, -1);
        check("p2_order_len", order_q.size(), 3);
        check("p2_first", order_q[0], 11);
        check("p2_second", order_q[1], 0);
        check("p2_third", order_q[2], 5);
        check("p2_gap_a", sop_cyc_q[1] - sop_cyc_q[0], 3);
        check("p2_gap_b", sop_cyc_q[2] - sop_cyc_q[1], 3);
        check("p2_count", pkt_count, 5);

        // Backpressure 1,0,0,1 after the arbitration cycle.
        load_pkt(2, 3, 0);
        ready_pat = '{1, 1, 0, 0, 1};
        run_traffic(100, 100, -1);
        check("p3_channel", order_q[0], 2);

        // Repeated sop inside a packet passes through but raises the flag.
        load_pkt(9, 3, 1);
        run_traffic(100, 100, -1);
        check("p3_dup_sop_err", proto_err, 1);
        proto_err_clr = 1'b1;
        @(posedge clk); #1;
        proto_err_clr = 1'b0; m_err = 0;
        check("p3_err_cleared", proto_err, 0);

        // Enable dropped mid-packet: the packet still completes.
        port_enable = 12'h001;
        load_pkt(0, 3, 0);
        run_traffic(100, 100, 2);
        port_enable = '1;
        check("p4_channel", order_q[0], 0);
        check("p4_count", pkt_count, 8);

        // Random traffic.
        do_reset();
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 6; k++)
                load_pkt($urandom_range(N - 1), $urandom_range(4, 1), 0);
            run_traffic(70, 60, -1);
        end

        // Counter clear coincident with a completion, then a plain clear.
        in_valid[2] = 1'b1; in_sop[2] = 1'b1; in_eop[2] = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        pkt_count_clr = 1'b1;
        @(posedge clk); #1;
        check("clr_with_completion", pkt_count, 1);
        in_valid = '0;
        @(posedge clk); #1;
        check("clr_plain", pkt_count, 0);
        clear_inputs();

        // Valid without sop in IDLE, then clear racing a persisting violation.
        do_reset();
        in_valid[7] = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("p5_no_ready", in_ready, 0);
        @(posedge clk); #1;
        check("p5_err_set", proto_err, 1);
        check("p5_not_busy", busy, 0);
        proto_err_clr = 1'b1;
        @(posedge clk); #1;
        check("p5_set_wins", proto_err, 1);
        in_valid = '0;
        @(posedge clk); #1;
        check("p5_cleared", proto_err, 0);
        clear_inputs();

        // Reset in the middle of a port-1 packet.
        do_reset();
        load_pkt(4, 1, 0);
        run_traffic(100, 100, -1);
        in_valid[1] = 1'b1; in_sop[1] = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_sop[1] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("p6_busy", busy, 0);
        check("p6_in_ready", in_ready, 0);
        check("p6_out_valid", out_valid, 0);
        check("p6_count", pkt_count, 0);
        reset = 1'b0;
        clear_inputs();
        m_ptr = 0; m_count = 0; m_busy = 0; m_err = 0;
        load_pkt(1, 2, 0);
        run_traffic(100, 100, -1);
        check("p6_regrant", order_q[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
